// File: rtl/pcpi_div_arbiter.sv
// Shares one iterative PCPI divide/remainder coprocessor between two PCPI requesters:
// pre-decodes the divide family, grants round-robin, and steers the result to the owner only.
module pcpi_div_arbiter #(
    parameter logic [6:0] DIV_OPCODE = 7'b0110011,
    parameter logic [6:0] DIV_FUNCT7 = 7'b0000001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    input  logic [31:0] req0_insn,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    output logic        req0_wr,
    output logic [31:0] req0_rd,
    output logic        req0_wait,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_insn,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    output logic        req1_wr,
    output logic [31:0] req1_rd,
    output logic        req1_wait,
    output logic        req1_ready,
    output logic        cop_valid,
    output logic [31:0] cop_insn,
    output logic [31:0] cop_rs1,
    output logic [31:0] cop_rs2,
    input  logic        cop_wr,
    input  logic [31:0] cop_rd,
    input  logic        cop_wait,
    input  logic        cop_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  block_q, block_d;
    logic        cop_valid_q, cop_valid_d;
    logic [31:0] cop_insn_q, cop_insn_d;
    logic [31:0] cop_rs1_q, cop_rs1_d;
    logic [31:0] cop_rs2_q, cop_rs2_d;
    logic [1:0]  wait_q, wait_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  wr_q, wr_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;

    logic [1:0]  valid_s;
    logic [1:0]  hit_s;
    logic [1:0]  elig_s;
    logic        grant_s;
    logic        done_s;
    logic [1:0]  owner_oh_s;
    logic [1:0]  set_block_s;

    // Divider busy carries no information the ready pulse does not already give.
    logic unused_cop_wait_s;
    assign unused_cop_wait_s = cop_wait;

    // Pre-decode, eligibility and round-robin winner selection.
    always_comb begin
        valid_s    = {req1_valid, req0_valid};
        hit_s[0]   = req0_valid & (req0_insn[6:0] == DIV_OPCODE)
                   & (req0_insn[31:25] == DIV_FUNCT7) & req0_insn[14];
        hit_s[1]   = req1_valid & (req1_insn[6:0] == DIV_OPCODE)
                   & (req1_insn[31:25] == DIV_FUNCT7) & req1_insn[14];
        elig_s     = hit_s & ~block_q;
        done_s     = (state_q == ST_ISSUE) & cop_ready;
        owner_oh_s = owner_q ? 2'b10 : 2'b01;
        if (elig_s == 2'b11) begin
            grant_s = ~last_grant_q;
        end else if (elig_s[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state, operand latch and result steering.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cop_valid_d  = cop_valid_q;
        cop_insn_d   = cop_insn_q;
        cop_rs1_d    = cop_rs1_q;
        cop_rs2_d    = cop_rs2_q;
        ready_d      = 2'b00;
        wr_d         = 2'b00;
        rd0_d        = 32'h0000_0000;
        rd1_d        = 32'h0000_0000;
        set_block_s  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != 2'b00) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    cop_valid_d  = 1'b1;
                    cop_insn_d   = grant_s ? req1_insn : req0_insn;
                    cop_rs1_d    = grant_s ? req1_rs1 : req0_rs1;
                    cop_rs2_d    = grant_s ? req1_rs2 : req0_rs2;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cop_ready) begin
                    cop_valid_d = 1'b0;
                    state_d     = ST_COOL;
                    // An owner that already let go gets nothing; the divider cannot be aborted.
                    if ((valid_s & owner_oh_s) != 2'b00) begin
                        ready_d     = owner_oh_s;
                        wr_d        = cop_wr ? owner_oh_s : 2'b00;
                        set_block_s = owner_oh_s;
                        if (owner_q) begin
                            rd1_d = cop_rd;
                        end else begin
                            rd0_d = cop_rd;
                        end
                    end else begin
                        set_block_s = 2'b00;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_COOL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                cop_valid_d = 1'b0;
            end
        endcase
        // Block keeps a still-asserted, already-served valid from being granted again.
        block_d = valid_s & (block_q | set_block_s);
        wait_d  = hit_s & ~block_q & ~(done_s ? owner_oh_s : 2'b00);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            block_q      <= 2'b00;
            cop_valid_q  <= 1'b0;
            cop_insn_q   <= 32'h0000_0000;
            cop_rs1_q    <= 32'h0000_0000;
            cop_rs2_q    <= 32'h0000_0000;
            wait_q       <= 2'b00;
            ready_q      <= 2'b00;
            wr_q         <= 2'b00;
            rd0_q        <= 32'h0000_0000;
            rd1_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            block_q      <= block_d;
            cop_valid_q  <= cop_valid_d;
            cop_insn_q   <= cop_insn_d;
            cop_rs1_q    <= cop_rs1_d;
            cop_rs2_q    <= cop_rs2_d;
            wait_q       <= wait_d;
            ready_q      <= ready_d;
            wr_q         <= wr_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign cop_valid  = cop_valid_q;
    assign cop_insn   = cop_insn_q;
    assign cop_rs1    = cop_rs1_q;
    assign cop_rs2    = cop_rs2_q;
    assign req0_wait  = wait_q[0];
    assign req1_wait  = wait_q[1];
    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_wr    = wr_q[0];
    assign req1_wr    = wr_q[1];
    assign req0_rd    = rd0_q;
    assign req1_rd    = rd1_q;

endmodule

// File: tb/tb_pcpi_div_arbiter.sv
// Randomised and directed bench for pcpi_div_arbiter: requester agents, a divider model
// and a cycle-level reference of the arbitration rules, compared every cycle.
module tb_pcpi_div_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_insn = 32'h0, req0_rs1 = 32'h0, req0_rs2 = 32'h0;
    logic [31:0] req1_insn = 32'h0, req1_rs1 = 32'h0, req1_rs2 = 32'h0;
    logic        req0_wr, req0_wait, req0_ready, req1_wr, req1_wait, req1_ready;
    logic [31:0] req0_rd, req1_rd;
    logic        cop_valid;
    logic [31:0] cop_insn, cop_rs1, cop_rs2;
    logic        cop_wr = 1'b0, cop_wait = 1'b0, cop_ready = 1'b0;
    logic [31:0] cop_rd = 32'h0;

    pcpi_div_arbiter dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_insn(req0_insn), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_wr(req0_wr), .req0_rd(req0_rd), .req0_wait(req0_wait), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_insn(req1_insn), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_wr(req1_wr), .req1_rd(req1_rd), .req1_wait(req1_wait), .req1_ready(req1_ready),
        .cop_valid(cop_valid), .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .cop_wr(cop_wr), .cop_rd(cop_rd), .cop_wait(cop_wait), .cop_ready(cop_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          abort;
        int          gap;
    } req_t;

    int n_checks = 0;
    int n_errors = 0;

    req_t        q0[$];
    req_t        q1[$];
    bit          a_active[2];
    int          a_abort[2];
    int          a_gap[2];
    int          a_gap_next[2];
    int          done_q[$];
    logic [31:0] last_rd[2];
    int          rst_cycles = 3;
    int          cv_cnt = 0;
    bit          have_exp = 1'b0;

    bit          d_busy = 1'b0;
    int          d_cnt = 0;
    int          d_lat = 0;
    bit          d_wr_rand = 1'b0;

    int          m_phase = 0;
    int          m_owner = 0;
    int          m_last = 1;
    bit          m_block[2];
    logic        e_cop_valid;
    logic [31:0] e_cop_insn, e_cop_rs1, e_cop_rs2;
    logic        e_wait[2], e_ready[2], e_wr[2];
    logic [31:0] e_rd[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_div(input logic [31:0] insn);
        return insn[6:0] == 7'b0110011 && insn[31:25] == 7'b0000001 && insn[14];
    endfunction

    // RISC-V M-extension divide/remainder semantics, including /0 and overflow.
    function automatic logic [31:0] ref_div(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (insn[13:12])
            2'b00: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            2'b01: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] gen_insn(input bit div);
        logic [31:0] w;
        w = $urandom;
        if (div) begin
            w[31:25] = 7'b0000001;
            w[14]    = 1'b1;
            w[6:0]   = 7'b0110011;
        end else begin
            case ($urandom % 3)
                0: begin w[31:25] = 7'b0000000; w[6:0] = 7'b0110011; end
                1: begin w[31:25] = 7'b0000001; w[14] = 1'b0; w[6:0] = 7'b0110011; end
                default: begin w[31:25] = 7'b0000001; w[14] = 1'b1; w[6:0] = 7'b0010011; end
            endcase
        end
        return w;
    endfunction

    function automatic req_t mk(input logic [31:0] insn, input logic [31:0] a,
                                input logic [31:0] b, input int abort, input int gap);
        req_t r;
        r.insn = insn; r.rs1 = a; r.rs2 = b; r.abort = abort; r.gap = gap;
        return r;
    endfunction

    function automatic bit busy();
        return q0.size() > 0 || q1.size() > 0 || a_active[0] || a_active[1] || m_phase != 0;
    endfunction

    task automatic compare_all();
        check_eq("cop_valid", 32'(cop_valid), 32'(e_cop_valid));
        check_eq("cop_insn", cop_insn, e_cop_insn);
        check_eq("cop_rs1", cop_rs1, e_cop_rs1);
        check_eq("cop_rs2", cop_rs2, e_cop_rs2);
        check_eq("req0_wait", 32'(req0_wait), 32'(e_wait[0]));
        check_eq("req1_wait", 32'(req1_wait), 32'(e_wait[1]));
        check_eq("req0_ready", 32'(req0_ready), 32'(e_ready[0]));
        check_eq("req1_ready", 32'(req1_ready), 32'(e_ready[1]));
        check_eq("req0_wr", 32'(req0_wr), 32'(e_wr[0]));
        check_eq("req1_wr", 32'(req1_wr), 32'(e_wr[1]));
        check_eq("req0_rd", req0_rd, e_rd[0]);
        check_eq("req1_rd", req1_rd, e_rd[1]);
    endtask

    task automatic drive_agents();
        req_t r;
        logic rdy;
        for (int i = 0; i < 2; i++) begin
            rdy = (i == 0) ? req0_ready : req1_ready;
            if (a_active[i]) begin
                if (rdy) begin
                    done_q.push_back(i);
                    last_rd[i]  = (i == 0) ? req0_rd : req1_rd;
                    a_active[i] = 1'b0;
                    a_gap[i]    = a_gap_next[i];
                end else if (a_abort[i] == 0) begin
                    a_active[i] = 1'b0;
                    a_gap[i]    = a_gap_next[i];
                end else if (a_abort[i] > 0) begin
                    a_abort[i]--;
                end
            end else if (a_gap[i] > 0) begin
                a_gap[i]--;
            end else if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
                r = (i == 0) ? q0.pop_front() : q1.pop_front();
                a_active[i]   = 1'b1;
                a_abort[i]    = r.abort;
                a_gap_next[i] = r.gap;
                if (i == 0) begin
                    req0_insn = r.insn; req0_rs1 = r.rs1; req0_rs2 = r.rs2;
                end else begin
                    req1_insn = r.insn; req1_rs1 = r.rs1; req1_rs2 = r.rs2;
                end
            end
        end
        req0_valid = a_active[0];
        req1_valid = a_active[1];
        if (!a_active[0]) req0_insn = $urandom;
        if (!a_active[1]) req1_insn = $urandom;
    endtask

    task automatic drive_divider();
        if (!resetn || cop_ready) begin
            cop_ready = 1'b0; cop_wr = 1'b0; cop_rd = 32'h0; d_busy = 1'b0;
        end else if (!d_busy && cop_valid) begin
            d_busy = 1'b1;
            d_cnt  = (d_lat > 0) ? d_lat : $urandom_range(1, 8);
        end else if (d_busy) begin
            d_cnt--;
            if (d_cnt == 0) begin
                cop_ready = 1'b1;
                cop_wr    = d_wr_rand ? ($urandom % 4 != 0) : 1'b1;
                cop_rd    = ref_div(cop_insn, cop_rs1, cop_rs2);
            end
        end
        cop_wait = d_busy;
    endtask

    // Expected outputs after the coming edge, from the arbitration rules.
    task automatic model_step();
        bit v[2], hit[2], setb[2], done;
        int g;
        v[0] = req0_valid; v[1] = req1_valid;
        hit[0] = req0_valid && is_div(req0_insn);
        hit[1] = req1_valid && is_div(req1_insn);
        for (int i = 0; i < 2; i++) begin
            e_ready[i] = 1'b0; e_wr[i] = 1'b0; e_rd[i] = 32'h0; setb[i] = 1'b0;
        end
        if (!resetn) begin
            e_cop_valid = 1'b0; e_cop_insn = 32'h0; e_cop_rs1 = 32'h0; e_cop_rs2 = 32'h0;
            m_phase = 0; m_owner = 0; m_last = 1;
            for (int i = 0; i < 2; i++) begin e_wait[i] = 1'b0; m_block[i] = 1'b0; end
        end else begin
            done = (m_phase == 1) && cop_ready;
            for (int i = 0; i < 2; i++)
                e_wait[i] = hit[i] && !m_block[i] && !(done && m_owner == i);
            if (m_phase == 0) begin
                if ((hit[0] && !m_block[0]) || (hit[1] && !m_block[1])) begin
                    if (hit[0] && !m_block[0] && hit[1] && !m_block[1]) g = 1 - m_last;
                    else g = (hit[0] && !m_block[0]) ? 0 : 1;
                    m_owner = g; m_last = g; e_cop_valid = 1'b1; m_phase = 1;
                    e_cop_insn = g ? req1_insn : req0_insn;
                    e_cop_rs1  = g ? req1_rs1 : req0_rs1;
                    e_cop_rs2  = g ? req1_rs2 : req0_rs2;
                end
            end else if (m_phase == 1) begin
                if (done) begin
                    e_cop_valid = 1'b0;
                    m_phase     = 2;
                    if (v[m_owner]) begin
                        e_ready[m_owner] = 1'b1;
                        e_wr[m_owner]    = cop_wr;
                        e_rd[m_owner]    = ref_div(e_cop_insn, e_cop_rs1, e_cop_rs2);
                        setb[m_owner]    = 1'b1;
                    end
                end
            end else begin
                m_phase = 0;
            end
            for (int i = 0; i < 2; i++) m_block[i] = v[i] && (m_block[i] || setb[i]);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (have_exp) compare_all();
        if (cop_valid) cv_cnt++;
        resetn = (rst_cycles == 0);
        if (rst_cycles > 0) rst_cycles--;
        drive_agents();
        drive_divider();
        model_step();
        have_exp = 1'b1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (busy() && n < budget);
        check_eq({tag, "_timeout"}, 32'(busy()), 32'd0);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst_cycles = 2;
        repeat (3) cycle();
    endtask

    localparam logic [31:0] I_DIV  = 32'h0200_4033;
    localparam logic [31:0] I_DIVU = 32'h0200_5033;
    localparam logic [31:0] I_REM  = 32'h0200_6033;
    localparam logic [31:0] I_REMU = 32'h0200_7033;
    localparam logic [31:0] I_ADD  = 32'h0000_0033;
    localparam logic [31:0] I_MUL  = 32'h0200_0033;

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_active[i] = 1'b0; a_abort[i] = -1; a_gap[i] = 0; a_gap_next[i] = 0;
            last_rd[i] = 32'h0; m_block[i] = 1'b0;
        end
        repeat (4) cycle();

        // Single signed divide with a slow divider.
        d_lat = 36;
        done_q.delete();
        q0.push_back(mk(I_DIV, 32'hFFFF_FFEC, 32'd3, -1, 0));
        run_until_idle("s1", 200);
        check_eq("s1_count", 32'(done_q.size()), 32'd1);
        check_eq("s1_rd", last_rd[0], 32'hFFFF_FFFA);

        // Simultaneous requests right after reset.
        do_reset();
        d_lat = 6;
        done_q.delete();
        q0.push_back(mk(I_DIVU, 32'd100, 32'd7, -1, 0));
        q1.push_back(mk(I_REMU, 32'd100, 32'd7, -1, 0));
        run_until_idle("s2", 200);
        check_eq("s2_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2) begin
            check_eq("s2_first", 32'(done_q[0]), 32'd0);
            check_eq("s2_second", 32'(done_q[1]), 32'd1);
        end
        check_eq("s2_rd0", last_rd[0], 32'd14);
        check_eq("s2_rd1", last_rd[1], 32'd2);

        // Both requesters streaming back-to-back divides.
        d_lat = 0;
        done_q.delete();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk(gen_insn(1'b1), rnd_op(), rnd_op(), -1, 0));
            q1.push_back(mk(gen_insn(1'b1), rnd_op(), rnd_op(), -1, 0));
        end
        run_until_idle("s3", 400);
        check_eq("s3_count", 32'(done_q.size()), 32'd8);
        for (int k = 0; k < done_q.size(); k++) check_eq("s3_order", 32'(done_q[k]), 32'(k % 2));

        // Non-divide instructions are never granted.
        cv_cnt = 0;
        done_q.delete();
        q1.push_back(mk(I_ADD, 32'd5, 32'd6, 20, 2));
        q1.push_back(mk(I_MUL, 32'd5, 32'd6, 20, 0));
        run_until_idle("s4", 200);
        check_eq("s4_cop_valid_cycles", 32'(cv_cnt), 32'd0);
        check_eq("s4_count", 32'(done_q.size()), 32'd0);

        // Owner abandons a remainder mid-operation, then issues a normal divide.
        d_lat = 12;
        done_q.delete();
        q0.push_back(mk(I_REM, 32'd7, 32'd0, 6, 20));
        q0.push_back(mk(I_DIV, 32'd50, 32'd5, -1, 0));
        run_until_idle("s5", 300);
        check_eq("s5_count", 32'(done_q.size()), 32'd1);
        check_eq("s5_rd", last_rd[0], 32'd10);

        // Reset in the middle of an operation with req1 queued behind it.
        d_lat = 30;
        done_q.delete();
        q0.push_back(mk(I_DIV, 32'd9, 32'd2, -1, 0));
        repeat (2) cycle();
        q1.push_back(mk(I_DIVU, 32'd81, 32'd9, -1, 0));
        repeat (8) cycle();
        rst_cycles = 1;
        a_abort[0] = 0;
        d_lat = 5;
        run_until_idle("s6", 300);
        check_eq("s6_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1) check_eq("s6_owner", 32'(done_q[0]), 32'd1);
        check_eq("s6_rd1", last_rd[1], 32'd9);

        // Random traffic: mixed families, gaps, abandons and write strobes.
        d_lat = 0;
        d_wr_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            bit div;
            int ab;
            div = ($urandom % 5) != 0;
            ab  = div ? ((($urandom % 6) == 0) ? int'($urandom_range(1, 10)) : -1)
                      : int'($urandom_range(3, 8));
            if (k % 2 == 0) q0.push_back(mk(gen_insn(div), rnd_op(), rnd_op(), ab, $urandom_range(0, 3)));
            else            q1.push_back(mk(gen_insn(div), rnd_op(), rnd_op(), ab, $urandom_range(0, 3)));
        end
        run_until_idle("s7", 3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
